// File: rtl/rx_gain_tune_controller.sv
// Retune sequencer and automatic CIC gain loop for the AM receiver.
// Define RX_GAIN_TUNE_CONTROLLER_AGC_EN to build the AGC; otherwise cic_gain follows cic_gain_manual.
module rx_gain_tune_controller #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned WINDOW      = 1024,
    parameter int unsigned SETTLE      = 8,
    parameter int unsigned HIGH_THRESH = 24576,
    parameter int unsigned LOW_THRESH  = 8192,
    parameter int unsigned GAIN_INIT   = 8,
    parameter int unsigned GAIN_MAX    = 15,
    parameter logic [31:0] RESET_PHASE = 32'h0
) (
    input  logic             clock,
    input  logic             clock_sreset,
    input  logic             tune_valid,
    input  logic [31:0]      tune_phase,
    output logic             tune_ready,
    input  logic [3:0]       cic_gain_manual,
    input  logic             demodulated_valid,
    input  logic [WIDTH-1:0] demodulated_out,
    output logic [31:0]      phase_increment,
    output logic [3:0]       cic_gain,
    output logic             mute,
    output logic             gain_locked
);

    typedef enum logic [1:0] {ST_SETTLE, ST_MEASURE, ST_ADJUST} state_t;

    localparam int unsigned    SW          = $clog2(SETTLE + 1);
    localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [3:0]     GAIN_RST    = 4'(GAIN_INIT);

    state_t        state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [31:0]   phase_q, phase_d;
    logic [3:0]    gain_q, gain_d;
    logic          mute_q, mute_d;
    logic          ready_q, ready_d;
    logic          locked_q, locked_d;

`ifdef RX_GAIN_TUNE_CONTROLLER_AGC_EN
    localparam int unsigned      WW       = $clog2(WINDOW);
    localparam logic [WW-1:0]    WIN_LAST = WW'(WINDOW - 1);
    localparam logic [WIDTH-1:0] MID      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-2:0] HIGH_T   = (WIDTH-1)'(HIGH_THRESH);
    localparam logic [WIDTH-2:0] LOW_T    = (WIDTH-1)'(LOW_THRESH);
    localparam logic [3:0]       GAIN_TOP = 4'(GAIN_MAX);

    logic [WW-1:0]    win_q, win_d;
    logic [WIDTH-2:0] peak_q, peak_d;
    logic             discard_q, discard_d;
    logic             hold_q, hold_d;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-2:0] dev;
    logic [3:0]       unused_manual;

    assign unused_manual = cic_gain_manual;

    // Distance from midscale; only a zero sample overflows WIDTH-1 bits.
    always_comb begin
        diff = (demodulated_out >= MID) ? (demodulated_out - MID) : (MID - demodulated_out);
        dev  = diff[WIDTH-1] ? '1 : diff[WIDTH-2:0];
    end
`else
    logic [WIDTH-1:0] unused_sample;

    assign unused_sample = demodulated_out;
`endif

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        phase_d  = phase_q;
        gain_d   = gain_q;
        locked_d = locked_q;
`ifdef RX_GAIN_TUNE_CONTROLLER_AGC_EN
        win_d     = win_q;
        peak_d    = peak_q;
        discard_d = discard_q;
        hold_d    = hold_q;
`else
        gain_d   = cic_gain_manual;
        locked_d = 1'b1;
`endif
        case (state_q)
            ST_SETTLE: begin
                if (demodulated_valid) begin
                    if (settle_q == SETTLE_LAST) begin
                        settle_d = '0;
                        state_d  = ST_MEASURE;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
            end
            ST_MEASURE: begin
`ifdef RX_GAIN_TUNE_CONTROLLER_AGC_EN
                if (demodulated_valid) begin
                    peak_d = (dev > peak_q) ? dev : peak_q;
                    if (win_q == WIN_LAST) begin
                        win_d   = '0;
                        state_d = ST_ADJUST;
                    end else begin
                        win_d = win_q + 1'b1;
                    end
                end
`endif
            end
`ifdef RX_GAIN_TUNE_CONTROLLER_AGC_EN
            ST_ADJUST: begin
                // A sample here opens the next window rather than being dropped.
                state_d = ST_MEASURE;
                peak_d  = demodulated_valid ? dev : '0;
                win_d   = demodulated_valid ? WW'(1) : '0;
                if (discard_q) begin
                    discard_d = 1'b0;
                end else if (peak_q >= HIGH_T && gain_q != '0) begin
                    gain_d    = gain_q - 1'b1;
                    locked_d  = 1'b0;
                    hold_d    = 1'b0;
                    discard_d = 1'b1;
                end else if (peak_q < LOW_T && gain_q < GAIN_TOP) begin
                    gain_d    = gain_q + 1'b1;
                    locked_d  = 1'b0;
                    hold_d    = 1'b0;
                    discard_d = 1'b1;
                end else begin
                    locked_d = locked_q | hold_q;
                    hold_d   = 1'b1;
                end
            end
`endif
            default: state_d = ST_SETTLE;
        endcase

        // Retune overrides any window result decided on the same edge.
        if (tune_valid && ready_q) begin
            state_d  = ST_SETTLE;
            settle_d = '0;
            phase_d  = tune_phase;
`ifdef RX_GAIN_TUNE_CONTROLLER_AGC_EN
            gain_d    = GAIN_RST;
            locked_d  = 1'b0;
            win_d     = '0;
            peak_d    = '0;
            discard_d = 1'b0;
            hold_d    = 1'b0;
`endif
        end

        mute_d  = (state_d == ST_SETTLE);
        ready_d = (state_d == ST_MEASURE);
    end

    always_ff @(posedge clock) begin
        if (clock_sreset) begin
            state_q  <= ST_SETTLE;
            settle_q <= '0;
            phase_q  <= RESET_PHASE;
            gain_q   <= GAIN_RST;
            mute_q   <= 1'b1;
            ready_q  <= 1'b0;
            locked_q <= 1'b0;
`ifdef RX_GAIN_TUNE_CONTROLLER_AGC_EN
            win_q     <= '0;
            peak_q    <= '0;
            discard_q <= 1'b0;
            hold_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            phase_q  <= phase_d;
            gain_q   <= gain_d;
            mute_q   <= mute_d;
            ready_q  <= ready_d;
            locked_q <= locked_d;
`ifdef RX_GAIN_TUNE_CONTROLLER_AGC_EN
            win_q     <= win_d;
            peak_q    <= peak_d;
            discard_q <= discard_d;
            hold_q    <= hold_d;
`endif
        end
    end

    assign phase_increment = phase_q;
    assign cic_gain        = gain_q;
    assign mute            = mute_q;
    assign tune_ready      = ready_q;
    assign gain_locked     = locked_q;

endmodule

// File: tb/tb_rx_gain_tune_controller.sv
// Directed scoreboard bench for rx_gain_tune_controller (AGC and manual-gain builds).
module tb_rx_gain_tune_controller;

    logic        clock = 1'b0;
    logic        clock_sreset;
    logic        tune_valid;
    logic [31:0] tune_phase;
    logic        tune_ready;
    logic [3:0]  cic_gain_manual;
    logic        demodulated_valid;
    logic [15:0] demodulated_out;
    logic [31:0] phase_increment;
    logic [3:0]  cic_gain;
    logic        mute;
    logic        gain_locked;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    int m_gain;
    bit m_discard;
    bit m_hold;
    bit m_locked;

    localparam int SEL_PHASE = 0, SEL_GAIN = 1, SEL_MUTE = 2, SEL_READY = 3, SEL_LOCK = 4;

    always #5 clock = ~clock;

    rx_gain_tune_controller #(
        .WIDTH(16),
        .WINDOW(8),
        .SETTLE(4),
        .HIGH_THRESH(24576),
        .LOW_THRESH(8192),
        .GAIN_INIT(8),
        .GAIN_MAX(15),
        .RESET_PHASE(32'h0)
    ) dut (
        .clock(clock),
        .clock_sreset(clock_sreset),
        .tune_valid(tune_valid),
        .tune_phase(tune_phase),
        .tune_ready(tune_ready),
        .cic_gain_manual(cic_gain_manual),
        .demodulated_valid(demodulated_valid),
        .demodulated_out(demodulated_out),
        .phase_increment(phase_increment),
        .cic_gain(cic_gain),
        .mute(mute),
        .gain_locked(gain_locked)
    );

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_PHASE: return phase_increment;
            SEL_GAIN:  return {28'd0, cic_gain};
            SEL_MUTE:  return {31'd0, mute};
            SEL_READY: return {31'd0, tune_ready};
            SEL_LOCK:  return {31'd0, gain_locked};
            default:   return '1;
        endcase
    endfunction

    function automatic logic [31:0] exp_gain();
`ifdef RX_GAIN_TUNE_CONTROLLER_AGC_EN
        return 32'(m_gain);
`else
        return {28'd0, cic_gain_manual};
`endif
    endfunction

    function automatic logic [31:0] exp_locked();
`ifdef RX_GAIN_TUNE_CONTROLLER_AGC_EN
        return {31'd0, m_locked};
`else
        return 32'd1;
`endif
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            total++;
            assert (obs === e.exp) else begin
                bad++;
                $error("FAIL %s sel=%0d observed=%0h expected=%0h", e.tag, e.sel, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic status(input string tag, input logic m, input logic r);
        push({tag, "_mute"}, SEL_MUTE, {31'd0, m});
        push({tag, "_ready"}, SEL_READY, {31'd0, r});
    endtask

    task automatic feed(input int n, input int unsigned base, input int unsigned amp);
        for (int i = 0; i < n; i++) begin
            demodulated_out   = (i % 2 == 0) ? 16'(base + amp) : 16'(base - amp);
            demodulated_valid = 1'b1;
            tick();
            demodulated_valid = 1'b0;
            tick();
        end
    endtask

    task automatic model_retune();
        m_gain    = 8;
        m_discard = 1'b0;
        m_hold    = 1'b0;
        m_locked  = 1'b0;
    endtask

    task automatic model_adjust(input int unsigned peak);
        if (m_discard) begin
            m_discard = 1'b0;
        end else if (peak >= 24576 && m_gain > 0) begin
            m_gain--;
            m_locked  = 1'b0;
            m_hold    = 1'b0;
            m_discard = 1'b1;
        end else if (peak < 8192 && m_gain < 15) begin
            m_gain++;
            m_locked  = 1'b0;
            m_hold    = 1'b0;
            m_discard = 1'b1;
        end else begin
            if (m_hold) m_locked = 1'b1;
            m_hold = 1'b1;
        end
    endtask

    // pre_done: first sample already delivered in the previous ADJUST cycle.
    // tail: next window's first sample arrives during this window's ADJUST cycle.
    task automatic agc_window(input string tag, input int unsigned base, input int unsigned amp,
                              input int unsigned peak, input bit pre_done, input bit tail);
        int n;
        n = pre_done ? 7 : 8;
        if (!tail) begin
            feed(n, base, amp);
        end else begin
            feed(n - 1, base, amp);
            demodulated_out   = 16'(base - amp);
            demodulated_valid = 1'b1;
            tick();
            demodulated_out   = 16'(base + amp);
            tick();
            demodulated_valid = 1'b0;
        end
        model_adjust(peak);
        push({tag, "_gain"}, SEL_GAIN, exp_gain());
        push({tag, "_lock"}, SEL_LOCK, exp_locked());
        status(tag, 1'b0, 1'b1);
        drain();
        if (tail) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clock_sreset      = 1'b1;
        tune_valid        = 1'b0;
        tune_phase        = 32'h0;
        cic_gain_manual   = 4'd5;
        demodulated_valid = 1'b0;
        demodulated_out   = 16'd32768;
        model_retune();

        // Reset values
        tick();
        tick();
        push("rst_phase", SEL_PHASE, 32'h0);
        push("rst_gain", SEL_GAIN, 32'd8);
        push("rst_lock", SEL_LOCK, 32'd0);
        status("rst", 1'b1, 1'b0);
        drain();

        clock_sreset = 1'b0;
        tick();
        push("rel_gain", SEL_GAIN, exp_gain());
        push("rel_lock", SEL_LOCK, exp_locked());
        status("rel", 1'b1, 1'b0);
        drain();

        for (int i = 0; i < 3; i++) begin
            feed(1, 32768, 0);
            status("settle0", 1'b1, 1'b0);
            push("settle0_phase", SEL_PHASE, 32'h0);
            push("settle0_gain", SEL_GAIN, exp_gain());
            drain();
        end
        feed(1, 32768, 0);
        status("settle0_done", 1'b0, 1'b1);
        push("settle0_done_phase", SEL_PHASE, 32'h0);
        push("settle0_done_gain", SEL_GAIN, exp_gain());
        drain();

        // Retune, then a held second request stalled through SETTLE
        tune_valid = 1'b1;
        tune_phase = 32'h0A3D70A4;
        tick();
        tune_valid = 1'b0;
        model_retune();
        push("rt1_phase", SEL_PHASE, 32'h0A3D70A4);
        push("rt1_gain", SEL_GAIN, exp_gain());
        push("rt1_lock", SEL_LOCK, exp_locked());
        status("rt1", 1'b1, 1'b0);
        drain();
        tick();
        tune_valid = 1'b1;
        tune_phase = 32'h12345678;
        tick();
        push("rt2_stall_phase", SEL_PHASE, 32'h0A3D70A4);
        status("rt2_stall", 1'b1, 1'b0);
        drain();
        for (int i = 0; i < 3; i++) begin
            feed(1, 32768, 0);
            push("rt2_held_phase", SEL_PHASE, 32'h0A3D70A4);
            status("rt2_held", 1'b1, 1'b0);
            drain();
        end
        demodulated_valid = 1'b1;
        tick();
        demodulated_valid = 1'b0;
        push("rt2_exit_phase", SEL_PHASE, 32'h0A3D70A4);
        status("rt2_exit", 1'b0, 1'b1);
        drain();
        tick();
        tune_valid = 1'b0;
        model_retune();
        push("rt2_take_phase", SEL_PHASE, 32'h12345678);
        status("rt2_take", 1'b1, 1'b0);
        drain();
        feed(3, 32768, 0);
        status("rt2_settle", 1'b1, 1'b0);
        drain();
        feed(1, 32768, 0);
        status("rt2_done", 1'b0, 1'b1);
        push("rt2_done_gain", SEL_GAIN, exp_gain());
        drain();

`ifdef RX_GAIN_TUNE_CONTROLLER_AGC_EN
        // Overload: full-scale deviation steps gain down to 0 then holds
        for (int w = 1; w <= 18; w++) begin
            agc_window("ovl", 65535, 0, 32767, w == 3, w == 2);
            if (w == 1) push("ovl_w1_gain", SEL_GAIN, 32'd7);
            if (w == 2) push("ovl_w2_gain", SEL_GAIN, 32'd7);
            if (w == 3) push("ovl_w3_gain", SEL_GAIN, 32'd6);
            if (w == 18) begin
                push("ovl_end_gain", SEL_GAIN, 32'd0);
                push("ovl_end_lock", SEL_LOCK, 32'd1);
            end
            drain();
        end

        // Quiet: gain climbs every second window to 15
        for (int w = 1; w <= 30; w++) begin
            agc_window("quiet", 32768, 100, 100, w == 6, w == 5);
            if (w == 1) push("quiet_w1_gain", SEL_GAIN, 32'd1);
            if (w == 30) begin
                push("quiet_end_gain", SEL_GAIN, 32'd15);
                push("quiet_end_lock", SEL_LOCK, 32'd0);
            end
            drain();
        end

        // Mid-level signal: two hold decisions lock the loop
        agc_window("mid1", 32768, 16000, 16000, 1'b0, 1'b0);
        push("mid1_lock_c", SEL_LOCK, 32'd0);
        drain();
        agc_window("mid2", 32768, 16000, 16000, 1'b0, 1'b0);
        push("mid2_lock_c", SEL_LOCK, 32'd1);
        push("mid2_gain_c", SEL_GAIN, 32'd15);
        drain();
`else
        // Manual gain: registered each cycle, no window effects
        feed(8, 65535, 0);
        push("man_win_gain", SEL_GAIN, 32'd5);
        push("man_win_lock", SEL_LOCK, 32'd1);
        status("man_win", 1'b0, 1'b1);
        drain();
        cic_gain_manual = 4'd3;
        push("man_pre_gain", SEL_GAIN, 32'd5);
        drain();
        tick();
        push("man_g3", SEL_GAIN, 32'd3);
        drain();
        cic_gain_manual = 4'd12;
        tick();
        push("man_g12", SEL_GAIN, 32'd12);
        drain();
        feed(8, 32768, 100);
        push("man_quiet_gain", SEL_GAIN, 32'd12);
        status("man_quiet", 1'b0, 1'b1);
        drain();
        cic_gain_manual = 4'd5;
        tick();
`endif

        // Collision: retune on the window-end edge with overload pending
        feed(7, 65535, 0);
        demodulated_out   = 16'd65535;
        demodulated_valid = 1'b1;
        tune_valid        = 1'b1;
        tune_phase        = 32'h5A5A0001;
        tick();
        demodulated_valid = 1'b0;
        tune_valid        = 1'b0;
        model_retune();
        push("col_phase", SEL_PHASE, 32'h5A5A0001);
        push("col_gain", SEL_GAIN, exp_gain());
        push("col_lock", SEL_LOCK, exp_locked());
        status("col", 1'b1, 1'b0);
        drain();
        tick();
        tick();
        push("col_after_gain", SEL_GAIN, exp_gain());
        push("col_after_lock", SEL_LOCK, exp_locked());
        status("col_after", 1'b1, 1'b0);
        drain();
        feed(3, 65535, 0);
        status("col_settle", 1'b1, 1'b0);
        drain();
        feed(1, 65535, 0);
        status("col_done", 1'b0, 1'b1);
        push("col_done_gain", SEL_GAIN, exp_gain());
        drain();

        // Reset in the middle of SETTLE restarts the settle count
        tune_valid = 1'b1;
        tune_phase = 32'hDEADBEEF;
        tick();
        tune_valid = 1'b0;
        push("mid_rt_phase", SEL_PHASE, 32'hDEADBEEF);
        drain();
        feed(2, 32768, 0);
        clock_sreset = 1'b1;
        tick();
        model_retune();
        push("mrst_phase", SEL_PHASE, 32'h0);
        push("mrst_gain", SEL_GAIN, 32'd8);
        push("mrst_lock", SEL_LOCK, 32'd0);
        status("mrst", 1'b1, 1'b0);
        drain();
        clock_sreset = 1'b0;
        tick();
        push("mrel_gain", SEL_GAIN, exp_gain());
        push("mrel_lock", SEL_LOCK, exp_locked());
        drain();
        for (int i = 0; i < 3; i++) begin
            feed(1, 32768, 0);
            status("mrst_settle", 1'b1, 1'b0);
            push("mrst_settle_phase", SEL_PHASE, 32'h0);
            drain();
        end
        feed(1, 32768, 0);
        status("mrst_done", 1'b0, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
